// File: rtl/rf_writeback_ctrl_if.sv
// Signal bundle between the pipeline and the register-file writeback controller.
// Load return: a beat transfers on a rising edge where ld_valid & ld_ready are both 1;
// ld_ready does not depend on ld_valid, and the ALU stream is valid-only with no backpressure.
interface rf_writeback_ctrl_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        iss_valid;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [4:0]  iss_rd;
    logic        iss_is_load;
    logic        iss_stall;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] pending;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_is_load,
        input  iss_stall,
        input  we3, a3, wd3, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_is_load,
        output iss_stall,
        output we3, a3, wd3, pending
    );
endinterface

// File: rtl/rf_writeback_ctrl.sv
// Merges ALU results and buffered load returns onto the single register-file write port,
// and tracks outstanding loads to stall issue on RAW/WAW hazards.
module rf_writeback_ctrl #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input logic              clk,
    input logic              rst,
    rf_writeback_ctrl_if.slave wb
);

    logic             buf_valid_q, buf_valid_d;
    logic [4:0]       buf_rd_q, buf_rd_d;
    logic [31:0]      buf_data_q, buf_data_d;
    logic             we3_q, we3_d;
    logic [4:0]       a3_q, a3_d;
    logic [31:0]      wd3_q, wd3_d;
    logic [31:0]      pending_q, pending_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic drain;
    logic starve;
    logic hz;
    logic issue_ld;

    // The buffer only drains when the ALU leaves the port idle.
    assign drain    = buf_valid_q & ~wb.alu_valid;
    assign starve   = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    assign hz       = pending_q[wb.iss_rs1] | pending_q[wb.iss_rs2] | pending_q[wb.iss_rd];
    assign issue_ld = wb.iss_valid & ~wb.iss_stall & wb.iss_is_load & (wb.iss_rd != 5'd0);

    assign wb.ld_ready  = ~buf_valid_q;
    assign wb.iss_stall = wb.iss_valid & (hz | starve);
    assign wb.we3       = we3_q;
    assign wb.a3        = a3_q;
    assign wb.wd3       = wd3_q;
    assign wb.pending   = pending_q;

    always_comb begin
        buf_valid_d  = buf_valid_q;
        buf_rd_d     = buf_rd_q;
        buf_data_d   = buf_data_q;
        we3_d        = 1'b0;
        a3_d         = a3_q;
        wd3_d        = wd3_q;
        pending_d    = pending_q;
        starve_cnt_d = starve_cnt_q;

        if (wb.alu_valid) begin
            we3_d = (wb.alu_rd != 5'd0);
            a3_d  = wb.alu_rd;
            wd3_d = wb.alu_data;
        end else if (buf_valid_q) begin
            we3_d       = (buf_rd_q != 5'd0);
            a3_d        = buf_rd_q;
            wd3_d       = buf_data_q;
            buf_valid_d = 1'b0;
        end

        // Capture is only possible while empty, so it never overlaps a drain.
        if (wb.ld_valid && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_rd_d    = wb.ld_rd;
            buf_data_d  = wb.ld_data;
        end

        if (buf_valid_q && wb.alu_valid) begin
            if (!starve) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = '0;
        end

        // Set is applied after clear so a same-index collision leaves the bit set.
        if (drain)    pending_d[buf_rd_q]  = 1'b0;
        if (issue_ld) pending_d[wb.iss_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid_q  <= 1'b0;
            buf_rd_q     <= '0;
            buf_data_q   <= '0;
            we3_q        <= 1'b0;
            a3_q         <= '0;
            wd3_q        <= '0;
            pending_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_rd_q     <= buf_rd_d;
            buf_data_q   <= buf_data_d;
            we3_q        <= we3_d;
            a3_q         <= a3_d;
            wd3_q        <= wd3_d;
            pending_q    <= pending_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: vector table for ALU/issue behaviour,
// hand sequences for load, collision, starvation and reset corners, write-port scoreboard.
module tb_rf_writeback_ctrl;

  logic clk;
  logic rst;

  rf_writeback_ctrl_if wb ();

  rf_writeback_ctrl #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] exp_q[$];

  typedef struct {
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        iss_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        is_load;
    logic        exp_stall;
    logic        exp_we;
    logic [31:0] exp_pend;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.alu_valid   = 1'b0;
    wb.alu_rd      = '0;
    wb.alu_data    = '0;
    wb.ld_valid    = 1'b0;
    wb.ld_rd       = '0;
    wb.ld_data     = '0;
    wb.iss_valid   = 1'b0;
    wb.iss_rs1     = '0;
    wb.iss_rs2     = '0;
    wb.iss_rd      = '0;
    wb.iss_is_load = 1'b0;
  endtask

  task automatic push_wr(input logic [4:0] rd, input logic [31:0] data);
    if (rd != 5'd0) exp_q.push_back({rd, data});
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    wb.alu_valid = 1'b1;
    wb.alu_rd    = rd;
    wb.alu_data  = data;
    push_wr(rd, data);
  endtask

  // Write-port monitor: every we3 pulse must match the oldest expected write.
  initial begin
    logic [36:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (wb.we3 === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wr_unexpected: got a3=%0d wd3=%h expected no write", wb.a3, wb.wd3);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr_data", {27'd0, wb.a3, wb.wd3}, {27'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_we;
    logic [4:0] r;
    logic [31:0] d;

    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 32'h0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 5'd0,  32'h00001111, 1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd1,  5'd2, 5'd3,  1'b0, 1'b0, 1'b1, 32'h0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0, 5'd7,  1'b1, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd0, 5'd9,  1'b0, 1'b1, 1'b0, 32'h80};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd7, 5'd8,  1'b0, 1'b1, 1'b0, 32'h80};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0, 5'd7,  1'b1, 1'b1, 1'b0, 32'h80};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 32'h80};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  5'd7, 5'd7,  1'b0, 1'b0, 1'b0, 32'h80};
    tbl[10] = '{1'b1, 5'd12, 32'h0BADF00D, 1'b1, 5'd12, 5'd0, 5'd13, 1'b0, 1'b0, 1'b1, 32'h80};

    // Reset held two cycles with every valid asserted.
    rst = 1'b0;
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'h33333333;
    wb.ld_valid = 1'b1; wb.ld_rd = 5'd6; wb.ld_data = 32'h66666666;
    wb.iss_valid = 1'b1; wb.iss_rs1 = 5'd0; wb.iss_rs2 = 5'd0; wb.iss_rd = 5'd4; wb.iss_is_load = 1'b1;
    step();
    step();
    chk("rst_we3", 64'(wb.we3), 64'd0);
    chk("rst_a3", 64'(wb.a3), 64'd0);
    chk("rst_wd3", 64'(wb.wd3), 64'd0);
    chk("rst_pending", 64'(wb.pending), 64'd0);
    chk("rst_ld_ready", 64'(wb.ld_ready), 64'd1);
    rst = 1'b1;
    idle();

    // Table: ALU writes, x0 suppression, pending set and hazard stalls.
    prev_we = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      chk($sformatf("tbl%0d_we3", i), 64'(wb.we3), 64'(prev_we));
      chk($sformatf("tbl%0d_pending", i), 64'(wb.pending), 64'(tbl[i].exp_pend));
      idle();
      if (tbl[i].alu_valid) drive_alu(tbl[i].alu_rd, tbl[i].alu_data);
      wb.iss_valid   = tbl[i].iss_valid;
      wb.iss_rs1     = tbl[i].rs1;
      wb.iss_rs2     = tbl[i].rs2;
      wb.iss_rd      = tbl[i].rd;
      wb.iss_is_load = tbl[i].is_load;
      #1;
      chk($sformatf("tbl%0d_stall", i), 64'(wb.iss_stall), 64'(tbl[i].exp_stall));
      prev_we = tbl[i].exp_we;
    end
    step();
    chk("tbl_last_we3", 64'(wb.we3), 64'(prev_we));

    // Load return to x7 clears the hazard two cycles after ld_valid.
    idle();
    wb.ld_valid = 1'b1; wb.ld_rd = 5'd7; wb.ld_data = 32'h00001234;
    wb.iss_valid = 1'b1; wb.iss_rs1 = 5'd7;
    #1;
    chk("ld_stall_before", 64'(wb.iss_stall), 64'd1);
    chk("ld_ready_empty", 64'(wb.ld_ready), 64'd1);
    step();
    wb.ld_valid = 1'b0;
    push_wr(5'd7, 32'h00001234);
    #1;
    chk("ld_ready_full", 64'(wb.ld_ready), 64'd0);
    chk("ld_we3_capture", 64'(wb.we3), 64'd0);
    chk("ld_pending_held", 64'(wb.pending), 64'h80);
    chk("ld_stall_held", 64'(wb.iss_stall), 64'd1);
    step();
    chk("ld_we3_drain", 64'(wb.we3), 64'd1);
    chk("ld_a3_drain", 64'(wb.a3), 64'd7);
    chk("ld_pending_clr", 64'(wb.pending), 64'd0);
    #1;
    chk("ld_stall_clear", 64'(wb.iss_stall), 64'd0);
    chk("ld_ready_again", 64'(wb.ld_ready), 64'd1);
    idle();

    // Random ALU burst.
    for (int k = 0; k < 8; k++) begin
      step();
      r = 5'($urandom_range(1, 31));
      d = $urandom;
      drive_alu(r, d);
    end
    step();
    idle();
    step();

    // Collision: three ALU writes pre-empt the buffered load.
    wb.ld_valid = 1'b1; wb.ld_rd = 5'd10; wb.ld_data = 32'hCAFE0010;
    for (int k = 1; k <= 3; k++) begin
      step();
      idle();
      drive_alu(5'(k), 32'h100 + 32'(k));
      #1;
      chk($sformatf("col%0d_ld_ready", k), 64'(wb.ld_ready), 64'd0);
    end
    step();
    idle();
    push_wr(5'd10, 32'hCAFE0010);
    wb.iss_valid = 1'b1; wb.iss_rs1 = 5'd1; wb.iss_rs2 = 5'd2; wb.iss_rd = 5'd3;
    #1;
    chk("col_drain_ld_ready", 64'(wb.ld_ready), 64'd0);
    chk("col_stall_below_limit", 64'(wb.iss_stall), 64'd0);
    step();
    chk("col_we3_load", 64'(wb.we3), 64'd1);
    chk("col_a3_load", 64'(wb.a3), 64'd10);
    chk("col_ld_ready_after", 64'(wb.ld_ready), 64'd1);
    idle();

    // Starvation: stall appears once the counter reaches the limit and saturates.
    wb.ld_valid = 1'b1; wb.ld_rd = 5'd11; wb.ld_data = 32'h57575757;
    for (int k = 0; k < 6; k++) begin
      step();
      idle();
      drive_alu(5'(20 + k), $urandom);
      wb.iss_valid = 1'b1; wb.iss_rs1 = 5'd1; wb.iss_rs2 = 5'd2; wb.iss_rd = 5'd3;
      #1;
      chk($sformatf("starve%0d_stall", k), 64'(wb.iss_stall), (k >= 4) ? 64'd1 : 64'd0);
    end
    step();
    wb.alu_valid = 1'b0;
    push_wr(5'd11, 32'h57575757);
    #1;
    chk("starve_drain_stall", 64'(wb.iss_stall), 64'd1);
    step();
    chk("starve_we3_load", 64'(wb.a3), 64'd11);
    #1;
    chk("starve_stall_clear", 64'(wb.iss_stall), 64'd0);
    idle();

    // Reset mid-operation drops the buffered load and the pending bit.
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd9; wb.iss_is_load = 1'b1;
    #1;
    chk("rmid_issue_stall", 64'(wb.iss_stall), 64'd0);
    step();
    idle();
    wb.ld_valid = 1'b1; wb.ld_rd = 5'd9; wb.ld_data = 32'h00000099;
    chk("rmid_pending_set", 64'(wb.pending), 64'h200);
    step();
    wb.ld_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rmid_ld_ready_full", 64'(wb.ld_ready), 64'd0);
    step();
    rst = 1'b1;
    chk("rmid_pending", 64'(wb.pending), 64'd0);
    chk("rmid_ld_ready", 64'(wb.ld_ready), 64'd1);
    chk("rmid_we3", 64'(wb.we3), 64'd0);
    step();
    chk("rmid_we3_next", 64'(wb.we3), 64'd0);
    step();
    chk("rmid_we3_next2", 64'(wb.we3), 64'd0);
    step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
- Writer side of the RV32I 32x32 register file.
- Arbitrates the single-cycle ALU result stream and the variable-latency load-return stream onto the register file's one write port (WE3/A3/WD3).
- Holds load data in a one-entry buffer until the port is free.
- Keeps a per-register pending-load scoreboard and stalls issue on RAW/WAW hazards against outstanding loads.

Parameters:
- STARVE_LIMIT, 4, number of consecutive cycles a buffered load may be blocked by ALU writes before issue is choked.
- CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- alu_valid  in  1  ALU result valid this cycle; has no backpressure.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_valid  in  1  load return valid.
- ld_rd  in  5  load destination register.
- ld_data  in  32  load data, already extended.
- ld_ready  out  1  load buffer can accept; equals buffer empty.
- iss_valid  in  1  issue stage presents an instruction.
- iss_rs1  in  5  source register 1.
- iss_rs2  in  5  source register 2.
- iss_rd  in  5  destination register.
- iss_is_load  in  1  instruction is a load.
- iss_stall  out  1  combinational stall to issue.
- we3  out  1  register file write enable, registered.
- a3  out  5  register file write address, registered.
- wd3  out  32  register file write data, registered.
- pending  out  32  scoreboard bitmap; bit 0 is always 0.

Behaviour:
- Reset (rst=0 at a rising edge):
  - we3=0, a3=0, wd3=0, pending=0.
  - Load buffer empty, so ld_ready=1 in the following cycle.
  - Starvation counter=0.
  - Any buffered load is discarded; reset mid-operation drops in-flight data silently.
- Load buffer:
  - Captures ld_rd/ld_data on a cycle with ld_valid & ld_ready.
  - The buffer cannot capture and drain in the same cycle; ld_ready stays 0 until the cycle after the drain.
- Write port priority, evaluated each cycle:
  - alu_valid=1: the ALU result is registered to we3/a3/wd3 next edge.
  - Otherwise, buffer full: the buffered load is registered and the buffer empties.
  - Otherwise: we3=0 next cycle, and a3/wd3 hold their previous values.
- Write-port latency is exactly 1 cycle from selection to we3 high.
- Writes with rd=0 from either source are consumed with we3=0. A buffered load to x0 still empties the buffer.
- Starvation counter:
  - Increments each cycle the buffer is full and alu_valid=1.
  - Resets to 0 when the buffer drains or is empty.
  - Saturates at STARVE_LIMIT.
  - starve = (counter == STARVE_LIMIT).
- iss_stall = iss_valid & (hz | starve), where hz = pending[iss_rs1] | pending[iss_rs2] | pending[iss_rd].
  - Index 0 never reports pending.
  - iss_is_load does not affect stalling itself.
- Scoreboard set: on iss_valid & !iss_stall & iss_is_load & iss_rd!=0, set pending[iss_rd] next edge.
- Scoreboard clear: when the buffered load drains, clear pending[buffer rd] next edge.
- Simultaneous set and clear of the same index: set wins.
  - This is unreachable in legal flow because issue to a pending rd stalls.
  - Set/clear of different indices both take effect.
- Upstream contract: ALU results never target a pending register; the issue stall guarantees this. The block does not check it.
- A load return whose rd is not pending is still written; no error is flagged.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all valids high -> we3=0, a3=0, wd3=0, pending=0, ld_ready=1 after release.
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF at cycle N -> we3=1, a3=5, wd3=0xDEADBEEF at N+1; we3=0 at N+2. With rd=0 -> we3 stays 0.
- Load hazard:
  - Issue a load, rd=7 -> pending[7]=1 next cycle.
  - Issue with rs1=7 -> iss_stall=1.
  - Return ld_rd=7, data=0x1234 with ALU idle -> write at +2 cycles from ld_valid (capture, drain); pending[7]=0 in the same cycle we3 rises; stall drops.
- Collision:
  - Buffer full and alu_valid=1 for 3 cycles -> three ALU writes, then the load write on the 4th cycle.
  - ld_ready=0 throughout, ld_ready=1 one cycle after the drain.
- Starvation: alu_valid held high with the buffer full for STARVE_LIMIT=4 cycles -> iss_stall=1 with iss_valid=1 and no hazard; stall clears after the ALU stream stops and the load drains.
- Reset mid-operation: buffer full, pending[9]=1, rst=0 for one cycle -> buffer empty, pending=0, the buffered load is never written.
